modn_counter: RTL and testbench
===============================

# modn_counter

Parametrised modulo-N synchronous up/down counter with an integrated clock-enable prescaler. It is the generalised successor to the fixed 3-bit modulo-8 LED counter. It replaces the derived-clock prescaler with a single-clock tick strobe and adds direction control, synchronous load, enable and a terminal-count pulse. It sits between the 12 MHz board clock and LED or other display logic; the top level maps `count` bits to LEDs.

## Interface

Parameters:
- `WIDTH`, 3: counter width in bits.
- `MODULUS`, 8: count range 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- `PSC_DIV`, 12000000: clk cycles per count step. Minimum 1; 1 means step every enabled cycle.

Ports:
- `clk`  in  1: single system clock. All logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: run enable. When low, the prescaler and the counter hold.
- `up`  in  1: direction. 1 counts up, 0 counts down.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  WIDTH: value captured on `load`.
- `count`  out  WIDTH: current count, registered.
- `tick`  out  1: prescaler step strobe, one clk wide.
- `tc`  out  1: terminal-count pulse, registered, one clk wide.

## Operation

- Prescaler register `psc` has width clog2(PSC_DIV), minimum 1 bit.
  - When `en`=1, it counts 0..PSC_DIV-1, then wraps to 0.
  - When `en`=0, it holds.
- `tick` = `en` AND (`psc` == PSC_DIV-1). For PSC_DIV=1, `tick` = `en`.
- Per-edge priority is fixed: `load`, then `tick`, then hold.
  - `load`=1:
    - `count` ← `load_val` if `load_val` < MODULUS, else MODULUS-1 (saturate).
    - `psc` ← 0.
    - `tc` ← 0.
    - Load ignores `en`.
  - `tick`=1 and `up`=1: `count` ← `count`+1, or 0 if `count`==MODULUS-1. On that wrap, `tc` ← 1.
  - `tick`=1 and `up`=0: `count` ← `count`-1, or MODULUS-1 if `count`==0. On that wrap, `tc` ← 1.
  - Otherwise `count` holds and `tc` ← 0.
- Arithmetic is done in WIDTH bits. The wrap compare is against MODULUS-1, never natural overflow, so non-power-of-two moduli are exact.
- Reset values: `count`=0, `psc`=0, `tc`=0. `tick`=0 except when PSC_DIV=1 and `en`=1.
- Reset mid-count clears everything immediately (asynchronously). The first step after release needs a full PSC_DIV enabled cycles.

## Timing

- `tick` is combinational from registered `psc` and `en`. `count` changes on the edge where `tick` is sampled high: 1-cycle latency from strobe to new value.
- `tc` rises on the same edge as the wrapping `count` update and stays high exactly one cycle. With PSC_DIV=1 and MODULUS=2, `tc` can be high on consecutive steps only at each wrap.
- `up` is sampled only on tick edges. A direction change mid-period takes effect at the next step, with no extra step.
- Deasserting `en` freezes the `psc` phase. Reasserting resumes from the same phase, with no lost or extra step.
- `load` coincident with `tick`: load wins. There is no step and no `tc`, and the prescaler phase restarts at 0.
- Parameter checks are elaboration-time. Illegal MODULUS or PSC_DIV must stop elaboration.

## Structure

- Shared package or include `modn_pkg`: the clog2 function, default constants (12 MHz board clock, 1 Hz step divisor) and the legality check macros.
- Sub-module `tick_gen`, parametrised by PSC_DIV:
  - Ports: `clk`, `rst`, `en`, `clr`, `tick`.
  - Instantiated once. It is reused by other blocks needing slow clock-enables.
- The top of the block holds the count/tc register logic only.
- Derived or gated clocks are forbidden. All state runs on `clk`.

## Test plan

- Up count, WIDTH=3, MODULUS=8, PSC_DIV=4, `en`=1, `up`=1:
  - `count` steps every 4 clks: 0,1,…,7,0.
  - `tc` is high for 1 clk with the 7→0 update.
  - `tick` duty is 1/4.
- Non-power-of-two down count, WIDTH=4, MODULUS=10, PSC_DIV=1, `up`=0, from reset:
  - Sequence 9,8,…,0,9 (first step wraps 0→9 with `tc`=1).
  - `tc` is also high on each later 0→9 wrap.
- Load saturation, MODULUS=10:
  - `load_val`=12 → `count`=9.
  - `load_val`=5 coincident with `tick` → `count`=5, no `tc`, next step exactly PSC_DIV clks later.
- Enable pause, PSC_DIV=4:
  - Drop `en` at `psc`=2 for 10 clks, then reassert.
  - Next step occurs 2 clks after reassertion. `count` is unchanged while low.
- Asynchronous reset mid-period:
  - Assert `rst` between edges with `count`=6, `psc`=3.
  - `count`, `psc` and `tc` go to 0 without a clk edge. After release, first step after PSC_DIV clks.
- Direction flip: toggle `up` between ticks at `count`=0. Next step goes to MODULUS-1 with `tc`=1, with no intermediate step.

Source files
------------

// File: rtl/modn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modn_pkg
//  Description : Shared constants and helpers for the modulo-N counter and
//                its prescaler: board clock defaults, clog2, and parameter
//                legality checks evaluated at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
package modn_pkg;

  // 12 MHz board clock, one count step per second by default.
  localparam int BOARD_CLK_HZ    = 12_000_000;
  localparam int STEP_HZ         = 1;
  localparam int DEFAULT_PSC_DIV = BOARD_CLK_HZ / STEP_HZ;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int clog2(input int value);
    longint v;
    int     result;
    v      = 1;
    result = 0;
    while (v < longint'(value)) begin
      v      = v << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // The prescaler register always needs at least one bit, even for PSC_DIV=1.
  function automatic int psc_width(input int div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

  // Legal modulus: 2 <= MODULUS <= 2^WIDTH.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (width <= 31) && (modulus >= 2) &&
           (longint'(modulus) <= (longint'(1) << width));
  endfunction

  // Legal divisor: at least one clk per step.
  function automatic bit psc_div_ok(input int div);
    return div >= 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Clock-enable prescaler. Produces a one-clk strobe every
//                PSC_DIV enabled cycles; no derived clocks.
//  Ports       : clk  - system clock (rising edge)
//                rst  - asynchronous active-high reset
//                en   - run enable; phase freezes while low
//                clr  - synchronous phase restart (wins over en)
//                tick - step strobe, combinational from phase and en
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import modn_pkg::*;
#(
  parameter int PSC_DIV = DEFAULT_PSC_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PSC_W = psc_width(PSC_DIV);
  localparam logic [PSC_W-1:0] c_PSC_LAST = PSC_W'(PSC_DIV - 1);

  if (!psc_div_ok(PSC_DIV)) begin : g_bad_psc_div
    $error("tick_gen: PSC_DIV must be >= 1");
  end

  logic [PSC_W-1:0] psc_q;
  logic [PSC_W-1:0] psc_d;
  logic             at_last;

  // With PSC_DIV=1 the phase is pinned at 0 and tick reduces to en.
  assign at_last = (psc_q == c_PSC_LAST);
  assign tick    = en & at_last;

  always_comb begin
    psc_d = psc_q;
    if (clr) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = at_last ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/modn_counter.sv
`default_nettype none
// ============================================================================
//  Module      : modn_counter
//  Description : Modulo-N up/down counter stepped by an integrated prescaler
//                strobe, with synchronous saturating load and a registered
//                terminal-count pulse on every wrap.
//  Ports       : clk      - system clock (rising edge)
//                rst      - asynchronous active-high reset
//                en       - run enable for prescaler and counter
//                up       - direction, 1 = up, 0 = down
//                load     - synchronous load strobe (ignores en)
//                load_val - load value, saturated to MODULUS-1
//                count    - registered count, 0..MODULUS-1
//                tick     - prescaler step strobe
//                tc       - registered one-clk wrap pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module modn_counter
  import modn_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int PSC_DIV = DEFAULT_PSC_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("modn_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS = 2^WIDTH is representable in the range compare.
  localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             load_in_range;

  // Load restarts the prescaler phase so the next step is a full period away.
  tick_gen #(
    .PSC_DIV (PSC_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign load_in_range = ({1'b0, load_val} < c_MOD_EXT);

  // Priority: load, then tick, then hold. Wraps compare against c_MAX rather
  // than relying on natural overflow so non-power-of-two moduli are exact.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_in_range ? load_val : c_MAX;
    end else if (tick) begin
      if (up) begin
        if (count_q == c_MAX) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = c_MAX;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_modn_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modn_counter
//  Description : Directed self-checking bench for modn_counter. Three
//                instances: A (W3, M8, PSC4), B (W4, M10, PSC1),
//                C (W4, M10, PSC4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modn_counter;

  logic clk;
  logic rst;

  logic       en_a, up_a, load_a, tick_a, tc_a;
  logic [2:0] load_val_a, count_a;
  logic       en_b, up_b, load_b, tick_b, tc_b;
  logic [3:0] load_val_b, count_b;
  logic       en_c, up_c, load_c, tick_c, tc_c;
  logic [3:0] load_val_c, count_c;

  int n_cmp;
  int n_err;

  modn_counter #(.WIDTH(3), .MODULUS(8), .PSC_DIV(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a),
    .load_val(load_val_a), .count(count_a), .tick(tick_a), .tc(tc_a)
  );

  modn_counter #(.WIDTH(4), .MODULUS(10), .PSC_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b),
    .load_val(load_val_b), .count(count_b), .tick(tick_b), .tc(tc_b)
  );

  modn_counter #(.WIDTH(4), .MODULUS(10), .PSC_DIV(4)) u_dut_c (
    .clk(clk), .rst(rst), .en(en_c), .up(up_c), .load(load_c),
    .load_val(load_val_c), .count(count_c), .tick(tick_c), .tc(tc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; load_val_a = '0;
    en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = '0;
    en_c = 1'b0; up_c = 1'b1; load_c = 1'b0; load_val_c = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_count_a", 32'(count_a), 0);
    check("rst_tc_a",    32'(tc_a),    0);
    check("rst_tick_a",  32'(tick_a),  0);
    check("rst_count_b", 32'(count_b), 0);
    check("rst_tick_b",  32'(tick_b),  0);

    // A: up count mod 8, a step every 4 clks, tc with the 7->0 update
    en_a = 1'b1;
    up_a = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      step();
      check("a_count", 32'(count_a), 32'((i / 4) % 8));
      check("a_tick",  32'(tick_a),  32'((i % 4) == 3));
      check("a_tc",    32'(tc_a),    32'(((i % 4) == 0) && (((i / 4) % 8) == 0)));
    end
    en_a = 1'b0;

    // B: PSC_DIV=1 down count mod 10 from reset: 9,8,...,0,9
    en_b = 1'b1;
    up_b = 1'b0;
    #1;
    check("b_tick_is_en", 32'(tick_b), 1);
    for (int j = 1; j <= 21; j++) begin
      step();
      check("b_count", 32'(count_b), 32'(((j % 10) == 0) ? 0 : 10 - (j % 10)));
      check("b_tc",    32'(tc_b),    32'((j % 10) == 1));
    end
    en_b = 1'b0;

    // C: load saturation (12 -> 9), load ignores en
    load_c = 1'b1;
    load_val_c = 4'd12;
    step();
    load_c = 1'b0;
    check("c_load_sat", 32'(count_c), 9);
    check("c_load_tc",  32'(tc_c),    0);

    // C: load of 5 coincident with tick at count 9 -> 5, no wrap, no tc
    en_c = 1'b1;
    up_c = 1'b1;
    repeat (3) step();
    check("c_pre_tick", 32'(tick_c),  1);
    check("c_pre_cnt",  32'(count_c), 9);
    load_c = 1'b1;
    load_val_c = 4'd5;
    step();
    load_c = 1'b0;
    check("c_load_tick_cnt", 32'(count_c), 5);
    check("c_load_tick_tc",  32'(tc_c),    0);
    repeat (3) step();
    check("c_after_load_hold", 32'(count_c), 5);
    check("c_after_load_tick", 32'(tick_c),  1);
    step();
    check("c_after_load_step", 32'(count_c), 6);
    check("c_after_load_tc",   32'(tc_c),    0);

    // C: pause at psc=2 for 10 clks, then next step 2 clks after resume
    repeat (2) step();
    en_c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("c_pause_cnt",  32'(count_c), 6);
      check("c_pause_tick", 32'(tick_c),  0);
    end
    en_c = 1'b1;
    step();
    check("c_resume_1", 32'(count_c), 6);
    step();
    check("c_resume_2", 32'(count_c), 7);

    // C: direction flip between ticks at count 0 -> 9 with tc, no extra step
    load_c = 1'b1;
    load_val_c = 4'd0;
    step();
    load_c = 1'b0;
    step();
    up_c = 1'b0;
    repeat (2) step();
    check("c_flip_hold", 32'(count_c), 0);
    step();
    check("c_flip_cnt", 32'(count_c), 9);
    check("c_flip_tc",  32'(tc_c),    1);
    step();
    check("c_flip_tc_clr", 32'(tc_c),    0);
    check("c_flip_cnt_2",  32'(count_c), 9);

    // C: asynchronous reset mid-period with count=6, psc=3
    up_c = 1'b1;
    load_c = 1'b1;
    load_val_c = 4'd6;
    step();
    load_c = 1'b0;
    repeat (3) step();
    check("c_prerst_cnt",  32'(count_c), 6);
    check("c_prerst_tick", 32'(tick_c),  1);
    #2;
    rst = 1'b1;
    #1;
    check("c_arst_cnt",  32'(count_c), 0);
    check("c_arst_tc",   32'(tc_c),    0);
    check("c_arst_tick", 32'(tick_c),  0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("c_postrst_hold", 32'(count_c), 0);
    check("c_postrst_tick", 32'(tick_c),  1);
    step();
    check("c_postrst_step", 32'(count_c), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
